// File: rtl/keypad_pkg.sv
// Shared types, key map and index helper for the keypad capture path.
package keypad_pkg;

  typedef enum logic [1:0] {IDLE, HELD, RELEASE} kp_state_t;

  // Index of the single low bit plus a flag saying exactly one bit was low.
  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } low_idx_t;

  // Digit at {row, col}. The first element in the concatenation is row3/col3.
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hF, 4'h0, 4'hE,  // row3
    4'hC, 4'h9, 4'h8, 4'h7,  // row2
    4'hB, 4'h6, 4'h5, 4'h4,  // row1
    4'hA, 4'h3, 4'h2, 4'h1   // row0
  };

  function automatic low_idx_t onehot_low_idx(input logic [3:0] v);
    low_idx_t    res;
    int unsigned zeros;
    res   = '0;
    zeros = 0;
    for (int i = 0; i < 4; i++) begin
      if (!v[i]) begin
        zeros   = zeros + 1;
        res.idx = 2'(i);
      end
    end
    res.valid = (zeros == 1);
    return res;
  endfunction

endpackage

// File: rtl/keypress_register_if.sv
// Scanner-side inputs and display-side outputs of the keypress register.
interface keypress_register_if;
  logic       key_press;
  logic [3:0] R;
  logic [3:0] C;
  logic [3:0] s1;
  logic [3:0] s2;
  logic       new_digit;
  logic       held;

  // master drives the scan inputs and observes the digits
  modport master (
    output key_press, R, C,
    input  s1, s2, new_digit, held
  );

  modport slave (
    input  key_press, R, C,
    output s1, s2, new_digit, held
  );
endinterface

// File: rtl/key_decode.sv
// Combinational map from active-low row/column lines to a hex digit.
module key_decode
  import keypad_pkg::*;
(
  input  logic [3:0] R,
  input  logic [3:0] C,
  output logic [3:0] digit,
  output logic [1:0] row,
  output logic [1:0] col,
  output logic       valid
);

  low_idx_t r_idx;
  low_idx_t c_idx;

  // Decode row and column independently; the digit only matters when valid.
  always_comb begin
    r_idx = onehot_low_idx(R);
    c_idx = onehot_low_idx(C);
    row   = r_idx.idx;
    col   = c_idx.idx;
    valid = r_idx.valid & c_idx.valid;
    digit = KEY_MAP[{r_idx.idx, c_idx.idx}];
  end

endmodule

// File: rtl/keypress_register.sv
// Captures one digit per key press and locks out the keypad until the
// locked key has read released for RELEASE_CYCLES samples of its column.
module keypress_register
  import keypad_pkg::*;
#(
  parameter int unsigned RELEASE_CYCLES = 10
) (
  input  logic                clk,
  input  logic                reset,
  keypress_register_if.slave  bus
);

  localparam int unsigned     CntW      = $clog2(RELEASE_CYCLES + 1);
  localparam logic [CntW-1:0] CntTarget = CntW'(RELEASE_CYCLES);
  localparam logic [CntW-1:0] CntMax    = '1;

  kp_state_t       state_q;
  logic [CntW-1:0] cnt_q;
  logic [1:0]      lock_row_q;
  logic [1:0]      lock_col_q;
  logic [3:0]      s1_q;
  logic [3:0]      s2_q;
  logic            new_digit_q;
  logic            held_q;

  logic [3:0]      dec_digit;
  logic [1:0]      dec_row;
  logic [1:0]      dec_col;
  logic            dec_valid;

  logic            accept;
  logic            lock_col_sample;
  logic            released;
  logic [CntW-1:0] cnt_inc;
  logic [3:0]      lock_col_pattern;

  key_decode u_key_decode (
    .R     (bus.R),
    .C     (bus.C),
    .digit (dec_digit),
    .row   (dec_row),
    .col   (dec_col),
    .valid (dec_valid)
  );

  // Qualify samples against the locked key; other columns are ignored entirely.
  always_comb begin
    accept                       = bus.key_press & dec_valid;
    lock_col_pattern             = 4'b1111;
    lock_col_pattern[lock_col_q] = 1'b0;
    lock_col_sample              = (bus.C == lock_col_pattern);
    released                     = bus.R[lock_row_q];
    cnt_inc                      = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
  end

  // Capture/lockout FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      lock_row_q  <= '0;
      lock_col_q  <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      new_digit_q <= 1'b0;
      held_q      <= 1'b0;
    end else begin
      new_digit_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            s2_q        <= s1_q;
            s1_q        <= dec_digit;
            new_digit_q <= 1'b1;
            lock_row_q  <= dec_row;
            lock_col_q  <= dec_col;
            cnt_q       <= '0;
            state_q     <= HELD;
            held_q      <= 1'b1;
          end
        end
        HELD: begin
          if (lock_col_sample && released) begin
            cnt_q <= CntW'(1);
            if (RELEASE_CYCLES == 1) begin
              state_q <= IDLE;
              held_q  <= 1'b0;
            end else begin
              state_q <= RELEASE;
            end
          end
        end
        RELEASE: begin
          if (lock_col_sample) begin
            if (!released) begin
              // Bounce: the key reads down again, restart the release count.
              cnt_q   <= '0;
              state_q <= HELD;
            end else begin
              cnt_q <= cnt_inc;
              if (cnt_inc >= CntTarget) begin
                state_q <= IDLE;
                held_q  <= 1'b0;
              end
            end
          end
        end
        default: begin
          state_q <= IDLE;
          held_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s1        = s1_q;
  assign bus.s2        = s2_q;
  assign bus.new_digit = new_digit_q;
  assign bus.held      = held_q;

endmodule

// File: tb/tb_keypress_register.sv
// Randomised and directed bench for keypress_register with a queue-based scoreboard.
module tb_keypress_register;

  localparam int unsigned RelCycles = 10;

  typedef struct {
    int         cyc;
    logic       held;
    logic       nd;
    logic [3:0] s1;
    logic [3:0] s2;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   scan_col = 0;
  exp_t exp_q[$];

  // reference model state: which key is locked and how many consecutive
  // released samples of its column have been seen
  bit         m_locked;
  int         m_row;
  int         m_col;
  int         m_rel;
  logic [3:0] m_s1;
  logic [3:0] m_s2;
  string      key_chars = "123A456B789CE0FD";

  keypress_register_if bus ();

  keypress_register #(
    .RELEASE_CYCLES (RelCycles)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int low_count(input logic [3:0] v);
    int n = 0;
    for (int i = 0; i < 4; i++) if (v[i] == 1'b0) n++;
    return n;
  endfunction

  function automatic int low_idx(input logic [3:0] v);
    int k = 0;
    for (int i = 0; i < 4; i++) if (v[i] == 1'b0) k = i;
    return k;
  endfunction

  function automatic logic [3:0] key_digit(input int r, input int c);
    byte ch;
    ch = key_chars[r * 4 + c];
    if (ch <= "9") return 4'(ch - "0");
    return 4'(ch - "A" + 10);
  endfunction

  // Apply one cycle of inputs, advance the model, queue the expected outputs.
  task automatic drive(input bit rst, input bit kp, input logic [3:0] r, input logic [3:0] c);
    exp_t       e;
    bit         nd;
    logic [3:0] lc;
    nd            = 1'b0;
    reset         = rst;
    bus.key_press = kp;
    bus.R         = r;
    bus.C         = c;
    if (rst) begin
      m_locked = 1'b0;
      m_rel    = 0;
      m_s1     = 4'h0;
      m_s2     = 4'h0;
    end else if (!m_locked) begin
      if (kp && low_count(r) == 1 && low_count(c) == 1) begin
        m_row    = low_idx(r);
        m_col    = low_idx(c);
        m_s2     = m_s1;
        m_s1     = key_digit(m_row, m_col);
        m_locked = 1'b1;
        m_rel    = 0;
        nd       = 1'b1;
      end
    end else begin
      lc        = 4'b1111;
      lc[m_col] = 1'b0;
      if (c == lc) begin
        if (r[m_row]) begin
          m_rel++;
          if (m_rel >= RelCycles) m_locked = 1'b0;
        end else begin
          m_rel = 0;
        end
      end
    end
    e.cyc  = cyc + 1;
    e.held = m_locked;
    e.nd   = nd;
    e.s1   = m_s1;
    e.s2   = m_s2;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Behave like the column scanner over a keypad with the given keys down.
  task automatic scan(input logic [15:0] pressed, input int n);
    logic [3:0] r;
    logic [3:0] c;
    for (int i = 0; i < n; i++) begin
      c           = 4'b1111;
      c[scan_col] = 1'b0;
      r           = 4'b1111;
      for (int k = 0; k < 4; k++) if (pressed[k * 4 + scan_col]) r[k] = 1'b0;
      drive(1'b0, r != 4'b1111, r, c);
      scan_col = (scan_col + 1) % 4;
    end
  endtask

  function automatic logic [15:0] key_bit(input int r, input int c);
    logic [15:0] m;
    m            = '0;
    m[r * 4 + c] = 1'b1;
    return m;
  endfunction

  // Scoreboard monitor: compare every queued expectation when its cycle comes up.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      n_checks++;
      n_errors++;
      $display("FAIL stale_expectation cyc=%0d got no sample, required one at cyc=%0d",
               cyc, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks++;
      if (bus.held !== e.held || bus.new_digit !== e.nd || bus.s1 !== e.s1 || bus.s2 !== e.s2) begin
        n_errors++;
        $display("FAIL outputs cyc=%0d got held=%b nd=%b s1=%h s2=%h required held=%b nd=%b s1=%h s2=%h",
                 cyc, bus.held, bus.new_digit, bus.s1, bus.s2, e.held, e.nd, e.s1, e.s2);
      end
    end
  end

  initial begin
    logic [15:0] pk;
    reset         = 1'b1;
    bus.key_press = 1'b0;
    bus.R         = 4'hF;
    bus.C         = 4'hE;

    // reset defaults, then the first press of key 1
    drive(1'b1, 1'b0, 4'hF, 4'hE);
    drive(1'b1, 1'b0, 4'hF, 4'hE);
    drive(1'b0, 1'b0, 4'hF, 4'hE);
    drive(1'b0, 1'b1, 4'b1110, 4'b1110);
    scan('0, 48);

    // hold key 5 with rotating columns, release, then press 0
    scan(key_bit(1, 1), 50);
    scan('0, 48);
    scan(key_bit(3, 1), 8);
    scan('0, 48);

    // release bounce on key 9 (row2, col2), interleaved with other columns
    drive(1'b0, 1'b1, 4'b1011, 4'b1011);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 4'hF, 4'b1011);
      drive(1'b0, 1'b0, 4'hF, 4'b1110);
    end
    drive(1'b0, 1'b1, 4'b1011, 4'b1011);
    for (int i = 0; i < RelCycles + 2; i++) begin
      drive(1'b0, 1'b0, 4'hF, 4'b1011);
      drive(1'b0, 1'b0, 4'hF, 4'b0111);
    end

    // invalid samples in IDLE
    drive(1'b0, 1'b1, 4'b1100, 4'b1110);
    drive(1'b0, 1'b1, 4'b1110, 4'b1100);
    drive(1'b0, 1'b1, 4'b1111, 4'b1110);
    drive(1'b0, 1'b0, 4'b1110, 4'b1110);
    drive(1'b0, 1'b1, 4'b1110, 4'b0000);

    // second key while held: A (row0,col3) then D (row3,col3) same column
    scan(key_bit(0, 3), 12);
    scan(key_bit(0, 3) | key_bit(3, 3), 12);
    scan(key_bit(3, 3), 60);
    scan('0, 48);

    // reset while held, key re-accepted afterwards
    scan(key_bit(2, 0), 10);
    drive(1'b1, 1'b1, 4'b1011, 4'b1110);
    scan(key_bit(2, 0), 10);
    scan('0, 48);

    // reset coinciding with a valid sample
    drive(1'b1, 1'b1, 4'b1110, 4'b1110);
    drive(1'b0, 1'b0, 4'hF, 4'hF);

    // randomised keypad activity with occasional glitches and resets
    for (int blk = 0; blk < 60; blk++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 3) pk = '0;
      else if (sel < 8) pk = key_bit(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      else pk = key_bit(int'($urandom_range(0, 3)), int'($urandom_range(0, 3))) |
                key_bit(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      for (int i = 0; i < int'($urandom_range(4, 50)); i++) begin
        sel = int'($urandom_range(0, 99));
        if (sel < 8) drive(1'b0, 1'($urandom), 4'($urandom), 4'($urandom));
        else if (sel == 8) drive(1'b1, 1'($urandom), 4'($urandom), 4'($urandom));
        else scan(pk, 1);
      end
    end
    scan('0, 48);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain got %0d pending expectations, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
